// File: rtl/datapath_pkg.sv
// Shared datapath types: result-stage FSM states and bus destination selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package datapath_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    EMIT_LO = 2'b01,
    EMIT_HI = 2'b10
  } zstage_state_t;

  localparam logic [1:0] SEL_GPR = 2'b00;
  localparam logic [1:0] SEL_LO  = 2'b01;
  localparam logic [1:0] SEL_HI  = 2'b10;

endpackage

// File: rtl/reg_en.sv
// Parameterised WIDTH-bit register with load enable and async active-low clear.
// Latency: q follows d one cycle after en is sampled high.
// Backpressure: none; holds its value whenever en is low.
module reg_en #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load on enable; clear forces zero asynchronously.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/z_result_stage.sv
// Captures the ALU result into Z and emits it to the bus: one GPR beat, or LO then HI beats for MUL/DIV.
// Latency: first beat valid the cycle after acceptance; one extra cycle for the HI beat.
// Backpressure: out_ready low holds the current beat stable; in_ready is high only in IDLE (no skid).
module z_result_stage
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] c_high,
  input  logic [WIDTH-1:0] c_low,
  input  logic             is_hilo,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic             busy
);

  zstage_state_t    state;
  zstage_state_t    state_nxt;
  logic             hilo_flag;
  logic [WIDTH-1:0] z_high;
  logic [WIDTH-1:0] z_low;
  logic             z_en;
  logic             lo_en;
  logic             hi_en;

  // Flush suppresses every write in the cycle it is asserted, including the
  // architectural LO/HI updates that would otherwise complete a beat.
  assign z_en  = (state == IDLE) && in_valid && !flush;
  assign lo_en = (state == EMIT_LO) && out_ready && hilo_flag && !flush;
  assign hi_en = (state == EMIT_HI) && out_ready && !flush;

  reg_en #(.WIDTH(WIDTH)) u_z_high (
    .clock (clock),
    .clear (clear),
    .en    (z_en),
    .d     (c_high),
    .q     (z_high)
  );

  reg_en #(.WIDTH(WIDTH)) u_z_low (
    .clock (clock),
    .clear (clear),
    .en    (z_en),
    .d     (c_low),
    .q     (z_low)
  );

  reg_en #(.WIDTH(WIDTH)) u_lo (
    .clock (clock),
    .clear (clear),
    .en    (lo_en),
    .d     (z_low),
    .q     (lo_q)
  );

  reg_en #(.WIDTH(WIDTH)) u_hi (
    .clock (clock),
    .clear (clear),
    .en    (hi_en),
    .d     (z_high),
    .q     (hi_q)
  );

  // State register and the MUL/DIV flag captured alongside Z.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      hilo_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (z_en) begin
        hilo_flag <= is_hilo;
      end
    end
  end

  // Next-state: advance on handshakes; flush overrides everything back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = EMIT_LO;
      EMIT_LO: if (out_ready) state_nxt = hilo_flag ? EMIT_HI : IDLE;
      EMIT_HI: if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  // Outputs decode registered state only; IDLE drives zeros so stale Z never leaks.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    out_data  = '0;
    out_sel   = SEL_GPR;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      EMIT_LO: begin
        out_valid = 1'b1;
        out_data  = z_low;
        out_sel   = hilo_flag ? SEL_LO : SEL_GPR;
      end
      EMIT_HI: begin
        out_valid = 1'b1;
        out_data  = z_high;
        out_sel   = SEL_HI;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_z_result_stage.sv
module tb_z_result_stage;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] c_high = '0;
  logic [W-1:0] c_low = '0;
  logic         is_hilo = 1'b0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   sel;
  } beat_t;
  beat_t sb[$];

  typedef struct {
    logic [W-1:0] ch;
    logic [W-1:0] cl;
    logic         hl;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  z_result_stage #(.WIDTH(W)) dut (
    .clock     (clock),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c_high    (c_high),
    .c_low     (c_low),
    .is_hilo   (is_hilo),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .hi_q      (hi_q),
    .lo_q      (lo_q),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Beat monitor: inputs change at posedge+1, so the negedge sees what the next edge will sample.
  always @(negedge clock) begin
    if (clear && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h/%0h required=none", out_data, out_sel);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_data", {32'h0, out_data}, {32'h0, e.data});
        chk("beat_sel", {62'h0, out_sel}, {62'h0, e.sel});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one result for a single cycle; the stage must be IDLE so it is accepted.
  task automatic send(input logic [W-1:0] ch, input logic [W-1:0] cl, input logic hl);
    beat_t b;
    chk("send_in_ready", {63'h0, in_ready}, 64'h1);
    c_high = ch;
    c_low = cl;
    is_hilo = hl;
    in_valid = 1'b1;
    b.data = cl;
    b.sel = hl ? 2'b01 : 2'b00;
    sb.push_back(b);
    if (hl) begin
      b.data = ch;
      b.sel = 2'b10;
      sb.push_back(b);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit rand_rdy);
    for (int i = 0; i < 60 && busy; i++) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    chk("drain_idle", {63'h0, busy}, 64'h0);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    out_ready = 1'b1;
  endtask

  vec_t vecs[6];
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0000_0007, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{32'h0000_0001, 32'h8000_0000, 1'b1, 32'h0000_0001, 32'h8000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 32'h0000_0001, 32'h8000_0000};
    vecs[3] = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[4] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A};
    vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A};

    // Reset state.
    #12;
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_out_data", {32'h0, out_data}, 64'h0);
    chk("rst_out_sel", {62'h0, out_sel}, 64'h0);
    chk("rst_hi_q", {32'h0, hi_q}, 64'h0);
    chk("rst_lo_q", {32'h0, lo_q}, 64'h0);
    @(negedge clock);
    clear = 1'b1;
    step();

    // Table: each result drained with random bus stalls.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].ch, vecs[i].cl, vecs[i].hl);
      drain(1'b1);
      chk("tbl_hi_q", {32'h0, hi_q}, {32'h0, vecs[i].exp_hi});
      chk("tbl_lo_q", {32'h0, lo_q}, {32'h0, vecs[i].exp_lo});
    end
    m_hi = 32'hA5A5_A5A5;
    m_lo = 32'h5A5A_5A5A;

    // ADD timing with out_ready held high.
    out_ready = 1'b1;
    send(32'h0, 32'h0000_0007, 1'b0);
    chk("add_valid_n1", {63'h0, out_valid}, 64'h1);
    chk("add_in_ready_n1", {63'h0, in_ready}, 64'h0);
    step();
    chk("add_valid_n2", {63'h0, out_valid}, 64'h0);
    chk("add_in_ready_n2", {63'h0, in_ready}, 64'h1);
    chk("add_idle_data", {32'h0, out_data}, 64'h0);
    chk("add_hi_q", {32'h0, hi_q}, {32'h0, m_hi});
    chk("add_lo_q", {32'h0, lo_q}, {32'h0, m_lo});

    // MUL timing: LO beat, then HI beat, then idle.
    send(32'h0000_0001, 32'h8000_0000, 1'b1);
    chk("mul_sel_lo", {62'h0, out_sel}, 64'h1);
    step();
    chk("mul_sel_hi", {62'h0, out_sel}, 64'h2);
    chk("mul_lo_q", {32'h0, lo_q}, 64'h8000_0000);
    chk("mul_hi_q_pending", {32'h0, hi_q}, {32'h0, m_hi});
    step();
    chk("mul_in_ready", {63'h0, in_ready}, 64'h1);
    chk("mul_hi_q", {32'h0, hi_q}, 64'h1);
    m_hi = 32'h1;
    m_lo = 32'h8000_0000;

    // Backpressure: beat held, new input refused, Z untouched.
    out_ready = 1'b0;
    send(32'h0000_0001, 32'h8000_0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      c_low = 32'hDEAD_BEEF;
      in_valid = 1'b1;
      chk("bp_out_data", {32'h0, out_data}, 64'h8000_0000);
      chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
      step();
    end
    in_valid = 1'b0;
    drain(1'b0);
    chk("bp_lo_q", {32'h0, lo_q}, 64'h8000_0000);
    chk("bp_hi_q", {32'h0, hi_q}, 64'h1);

    // Flush in IDLE with in_valid: nothing accepted.
    in_valid = 1'b1;
    flush = 1'b1;
    c_low = 32'h0000_0055;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_idle_busy", {63'h0, busy}, 64'h0);
    chk("flush_idle_valid", {63'h0, out_valid}, 64'h0);

    // Flush in EMIT_HI with out_ready high: LO kept, HI not written.
    send(32'h0000_00FF, 32'h0000_0042, 1'b1);
    step();
    chk("fl_in_emit_hi", {62'h0, out_sel}, 64'h2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    chk("fl_out_valid", {63'h0, out_valid}, 64'h0);
    chk("fl_busy", {63'h0, busy}, 64'h0);
    chk("fl_hi_q", {32'h0, hi_q}, {32'h0, m_hi});
    chk("fl_lo_q", {32'h0, lo_q}, 64'h42);
    chk("fl_sb_empty", 64'(sb.size()), 64'h0);

    // Async reset in the middle of EMIT_LO.
    out_ready = 1'b0;
    send(32'h0000_0011, 32'h0000_0099, 1'b1);
    chk("ar_pre_valid", {63'h0, out_valid}, 64'h1);
    #2;
    clear = 1'b0;
    #1;
    chk("ar_out_valid", {63'h0, out_valid}, 64'h0);
    chk("ar_in_ready", {63'h0, in_ready}, 64'h1);
    chk("ar_busy", {63'h0, busy}, 64'h0);
    chk("ar_out_data", {32'h0, out_data}, 64'h0);
    chk("ar_out_sel", {62'h0, out_sel}, 64'h0);
    chk("ar_hi_q", {32'h0, hi_q}, 64'h0);
    chk("ar_lo_q", {32'h0, lo_q}, 64'h0);
    sb.delete();
    out_ready = 1'b1;
    @(posedge clock);
    #3;
    clear = 1'b1;
    step();
    send(32'h0, 32'h0000_0003, 1'b0);
    drain(1'b0);
    chk("ar_post_hi_q", {32'h0, hi_q}, 64'h0);
    chk("ar_post_lo_q", {32'h0, lo_q}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z_result_stage.md
# z_result_stage

Result stage directly downstream of the datapath ALU. Captures the 64-bit ALU result (`c_high`/`c_low`) into the Z register, then delivers it to the bus over a valid/ready handshake. MUL/DIV results go out in two beats, LO then HI, and update the architectural LO and HI registers. All other results go out in one beat toward the destination GPR. It decouples the combinational ALU from bus arbitration, so the ALU operands are free as soon as the result is accepted.

## Interface
Parameters:
- `WIDTH`, 32, data width of each result half; Z is 2×WIDTH.

Ports:
- `clock`, in, 1, single clock; all state changes on the rising edge.
- `clear`, in, 1, asynchronous active-low reset.
- `in_valid`, in, 1, ALU result on `c_high`/`c_low` is valid this cycle.
- `in_ready`, out, 1, stage can accept a result.
- `c_high`, in, WIDTH, ALU high half (Chigh).
- `c_low`, in, WIDTH, ALU low half (Clow).
- `is_hilo`, in, 1, result comes from MUL or DIV; sampled with `in_valid`.
- `flush`, in, 1, synchronous abort of any held result.
- `out_valid`, out, 1, `out_data` holds a beat for the bus.
- `out_ready`, in, 1, bus consumer accepts the beat.
- `out_data`, out, WIDTH, beat payload.
- `out_sel`, out, 2, destination of the beat: 00 GPR, 01 LO, 10 HI; 11 unused.
- `hi_q`, out, WIDTH, architectural HI register.
- `lo_q`, out, WIDTH, architectural LO register.
- `busy`, out, 1, high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, EMIT_LO, EMIT_HI.
- **IDLE**
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`&`in_ready`: Z ← {c_high, c_low}, hilo_flag ← `is_hilo`, go to EMIT_LO.
- **EMIT_LO**
  - `out_valid`=1, `out_data`=Z[WIDTH-1:0], `out_sel`=01 if hilo_flag, else 00.
  - On `out_ready`: if hilo_flag, `lo_q` ← Z low and go to EMIT_HI; else go to IDLE.
- **EMIT_HI**
  - `out_valid`=1, `out_data`=Z[2·WIDTH-1:WIDTH], `out_sel`=10.
  - On `out_ready`: `hi_q` ← Z high, go to IDLE.
- `in_ready` = (state == IDLE) only. No acceptance on the same cycle as a final beat, and no skid buffer.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_sel` are held stable and Z is not rewritten.
- `flush` has priority over every handshake in the same cycle:
  - next state IDLE, Z and hilo_flag unchanged;
  - `hi_q`/`lo_q` not written, even if `out_ready` was high that cycle;
  - a flush in EMIT_HI leaves the already-written `lo_q` in place. This partial LO update is intended.
- `flush` in IDLE with `in_valid`=1: the input is not accepted.
- Values are pass-through; no arithmetic is performed. Z holds the full 64 bits unmodified.
- Outputs in IDLE: `out_data`=0, `out_sel`=00, so a stale Z never appears on the bus.

## Timing
- Reset (`clear`=0, asynchronous):
  - state=IDLE, Z=0, hilo_flag=0, `hi_q`=0, `lo_q`=0;
  - `out_valid`=0, `in_ready`=1, `busy`=0, `out_data`=0, `out_sel`=00.
- Reset asserted mid-transfer drops the transfer immediately, with no partial HI write.
- Result accepted at edge N → `out_valid`=1 from cycle N+1.
- With `out_ready` held high:
  - single-beat result: `out_valid` high for one cycle, `in_ready` high again at N+2;
  - two-beat result: LO beat at N+1, HI beat at N+2, `in_ready` high at N+3.
- `lo_q`/`hi_q` update on the edge that completes their beat, so they are visible the following cycle.
- All outputs are registered-state decodes. There is no combinational path from `out_ready` or `in_valid` to any output.

## Structure
- Shared package `datapath_pkg`:
  - state enum `zstage_state_t` (IDLE, EMIT_LO, EMIT_HI);
  - constants `SEL_GPR`=2'b00, `SEL_LO`=2'b01, `SEL_HI`=2'b10.
- Sub-module `reg_en`: a parameterised WIDTH-bit register with enable and async active-low clear. Instantiated for Z-high, Z-low, HI and LO.
- The FSM and the output mux live in `z_result_stage` itself.

## Test plan
- **ADD, single beat:** reset, then `in_valid`=1, `is_hilo`=0, c_high=0, c_low=32'h0000_0007, `out_ready`=1.
  - One beat `out_data`=7, `out_sel`=00.
  - `hi_q`/`lo_q` stay 0; `in_ready` returns 2 cycles after acceptance.
- **MUL, two beats:** c_high=32'h0000_0001, c_low=32'h8000_0000, `is_hilo`=1, `out_ready`=1.
  - Beats 32'h8000_0000/01, then 32'h0000_0001/10.
  - `lo_q`=32'h8000_0000, `hi_q`=1.
- **Backpressure:** as the MUL case but `out_ready`=0 for 5 cycles, with `c_low` changed to 32'hDEAD_BEEF while held.
  - `out_data` stays 32'h8000_0000, `in_ready`=0.
  - Z is unchanged and the new input is not accepted.
- **Flush in EMIT_HI with `out_ready`=1:**
  - `hi_q` keeps its old value, `lo_q` has the new LO.
  - state is IDLE next cycle, `out_valid`=0.
- **Async reset mid EMIT_LO (`clear` low between edges):**
  - all outputs go to their reset values immediately;
  - after release, a new ADD result of 3 emits correctly.
